// File: rtl/clock_update_sched_if.sv
// Signal bundle between the clock sequencer and its request sources / digit renderer.
// master drives requests and load data; slave (the sequencer) drives digits and status.
interface clock_update_sched_if;
    logic       upd_window;
    logic       tick_sec;
    logic       adj_sec;
    logic       adj_min;
    logic       adj_hrs;
    logic       load_req;
    logic [6:0] load_sec;
    logic [6:0] load_min;
    logic [5:0] load_hrs;
    logic [3:0] sec_u;
    logic [3:0] min_u;
    logic [3:0] hrs_u;
    logic [2:0] sec_d;
    logic [2:0] min_d;
    logic [1:0] hrs_d;
    logic [3:0] color_offset;
    logic       busy;
    logic       load_done;
    logic       load_err;
    logic       tick_lost;

    modport master (
        output upd_window, tick_sec, adj_sec, adj_min, adj_hrs, load_req,
        output load_sec, load_min, load_hrs,
        input  sec_u, min_u, hrs_u, sec_d, min_d, hrs_d,
        input  color_offset, busy, load_done, load_err, tick_lost
    );

    modport slave (
        input  upd_window, tick_sec, adj_sec, adj_min, adj_hrs, load_req,
        input  load_sec, load_min, load_hrs,
        output sec_u, min_u, hrs_u, sec_d, min_d, hrs_d,
        output color_offset, busy, load_done, load_err, tick_lost
    );
endinterface

// File: rtl/clock_update_sched.sv
// Single writer of the BCD HH:MM:SS registers and minute colour offset; arbitrates tick,
// adjust and load requests and applies one step per cycle only while upd_window allows.
module clock_update_sched #(
    parameter int unsigned HRS_WRAP    = 24,
    parameter int unsigned TICK_PEND_W = 2
) (
    input logic                 px_clk,
    input logic                 reset,
    clock_update_sched_if.slave bus
);
    typedef enum logic [2:0] {StIdle, StSec, StMin, StHrs, StLoad} state_e;

    localparam int unsigned HrsLast = HRS_WRAP - 1;
    localparam logic [5:0] HrsLastBcd = {2'(HrsLast / 10), 4'(HrsLast % 10)};
    localparam logic [TICK_PEND_W-1:0] TickMax = '1;

    state_e                 state_q, state_d;
    logic                   chain_q, chain_d;
    logic [6:0]             secs_q, secs_d, mins_q, mins_d;
    logic [5:0]             hours_q, hours_d;
    logic [3:0]             color_q, color_d;
    logic [TICK_PEND_W-1:0] tick_pend_q, tick_pend_d;
    logic                   pend_sec_q, pend_sec_d, pend_min_q, pend_min_d;
    logic                   pend_hrs_q, pend_hrs_d, pend_load_q, pend_load_d;
    logic [6:0]             sh_sec_q, sh_sec_d, sh_min_q, sh_min_d;
    logic [5:0]             sh_hrs_q, sh_hrs_d;
    logic                   load_done_q, load_done_d, load_err_q, load_err_d;
    logic                   tick_lost_q, tick_lost_d;

    logic       tick_nz, go, disp_load, disp_tick, disp_hrs, disp_min, disp_sec;
    logic [6:0] hrs_bin;
    logic       load_ok, load_flush;

    function automatic logic [6:0] inc_bcd60(input logic [6:0] v);
        logic [6:0] r;
        if (v == 7'h59)            r = 7'h00;
        else if (v[3:0] == 4'd9)   r = {v[6:4] + 3'd1, 4'd0};
        else                       r = {v[6:4], v[3:0] + 4'd1};
        return r;
    endfunction

    function automatic logic [5:0] inc_hrs(input logic [5:0] v);
        logic [5:0] r;
        if (v == HrsLastBcd)       r = 6'h00;
        else if (v[3:0] == 4'd9)   r = {v[5:4] + 2'd1, 4'd0};
        else                       r = {v[5:4], v[3:0] + 4'd1};
        return r;
    endfunction

    // Fixed priority: load > tick > hrs > min > sec, only from IDLE inside the window.
    always_comb begin
        tick_nz   = (tick_pend_q != '0);
        go        = (state_q == StIdle) && bus.upd_window;
        disp_load = go && pend_load_q;
        disp_tick = go && !pend_load_q && tick_nz;
        disp_hrs  = go && !pend_load_q && !tick_nz && pend_hrs_q;
        disp_min  = go && !pend_load_q && !tick_nz && !pend_hrs_q && pend_min_q;
        disp_sec  = go && !pend_load_q && !tick_nz && !pend_hrs_q && !pend_min_q && pend_sec_q;
    end

    always_comb begin
        hrs_bin = 7'(sh_hrs_q[5:4]) * 7'd10 + 7'(sh_hrs_q[3:0]);
        load_ok = (sh_sec_q[3:0] <= 4'd9) && (sh_sec_q[6:4] <= 3'd5) &&
                  (sh_min_q[3:0] <= 4'd9) && (sh_min_q[6:4] <= 3'd5) &&
                  (sh_hrs_q[3:0] <= 4'd9) && (32'(hrs_bin) < HRS_WRAP);
    end

    always_ff @(posedge px_clk) begin
        if (reset) begin
            state_q <= StIdle;
            chain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            chain_q <= chain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        chain_d = chain_q;
        case (state_q)
            StIdle: begin
                if (disp_load) begin
                    state_d = StLoad;
                end else if (disp_tick) begin
                    state_d = StSec;
                    chain_d = 1'b1;
                end else if (disp_hrs) begin
                    state_d = StHrs;
                    chain_d = 1'b0;
                end else if (disp_min) begin
                    state_d = StMin;
                    chain_d = 1'b0;
                end else if (disp_sec) begin
                    state_d = StSec;
                    chain_d = 1'b0;
                end
            end
            StSec:   state_d = (secs_q == 7'h59 && chain_q) ? StMin : StIdle;
            StMin:   state_d = (mins_q == 7'h59 && chain_q) ? StHrs : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.busy = (state_q != StIdle);
    end

    always_comb begin
        secs_d      = secs_q;
        mins_d      = mins_q;
        hours_d     = hours_q;
        color_d     = color_q;
        load_done_d = 1'b0;
        load_err_d  = load_err_q;
        load_flush  = 1'b0;
        case (state_q)
            StSec: secs_d = inc_bcd60(secs_q);
            StMin: begin
                mins_d  = inc_bcd60(mins_q);
                color_d = color_q + 4'd1;
            end
            StHrs: hours_d = inc_hrs(hours_q);
            StLoad: begin
                load_done_d = 1'b1;
                load_err_d  = !load_ok;
                if (load_ok) begin
                    secs_d     = sh_sec_q;
                    mins_d     = sh_min_q;
                    hours_d    = sh_hrs_q;
                    load_flush = 1'b1;
                end
            end
            default: ;
        endcase

        // A tick arriving in the flush cycle is newer than the load and survives it.
        tick_pend_d = tick_pend_q;
        tick_lost_d = tick_lost_q;
        if (load_flush) begin
            tick_pend_d = bus.tick_sec ? TICK_PEND_W'(1) : '0;
        end else if (bus.tick_sec && !disp_tick) begin
            if (tick_pend_q == TickMax) tick_lost_d = 1'b1;
            else                        tick_pend_d = tick_pend_q + TICK_PEND_W'(1);
        end else if (!bus.tick_sec && disp_tick) begin
            tick_pend_d = tick_pend_q - TICK_PEND_W'(1);
        end

        pend_sec_d  = (pend_sec_q && !disp_sec && !load_flush) || bus.adj_sec;
        pend_min_d  = (pend_min_q && !disp_min && !load_flush) || bus.adj_min;
        pend_hrs_d  = (pend_hrs_q && !disp_hrs && !load_flush) || bus.adj_hrs;
        pend_load_d = (pend_load_q && !disp_load) || bus.load_req;

        sh_sec_d = bus.load_req ? bus.load_sec : sh_sec_q;
        sh_min_d = bus.load_req ? bus.load_min : sh_min_q;
        sh_hrs_d = bus.load_req ? bus.load_hrs : sh_hrs_q;
    end

    always_ff @(posedge px_clk) begin
        if (reset) begin
            secs_q      <= '0;
            mins_q      <= '0;
            hours_q     <= '0;
            color_q     <= '0;
            tick_pend_q <= '0;
            tick_lost_q <= 1'b0;
            pend_sec_q  <= 1'b0;
            pend_min_q  <= 1'b0;
            pend_hrs_q  <= 1'b0;
            pend_load_q <= 1'b0;
            sh_sec_q    <= '0;
            sh_min_q    <= '0;
            sh_hrs_q    <= '0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            secs_q      <= secs_d;
            mins_q      <= mins_d;
            hours_q     <= hours_d;
            color_q     <= color_d;
            tick_pend_q <= tick_pend_d;
            tick_lost_q <= tick_lost_d;
            pend_sec_q  <= pend_sec_d;
            pend_min_q  <= pend_min_d;
            pend_hrs_q  <= pend_hrs_d;
            pend_load_q <= pend_load_d;
            sh_sec_q    <= sh_sec_d;
            sh_min_q    <= sh_min_d;
            sh_hrs_q    <= sh_hrs_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
        end
    end

    assign bus.sec_u        = secs_q[3:0];
    assign bus.sec_d        = secs_q[6:4];
    assign bus.min_u        = mins_q[3:0];
    assign bus.min_d        = mins_q[6:4];
    assign bus.hrs_u        = hours_q[3:0];
    assign bus.hrs_d        = hours_q[5:4];
    assign bus.color_offset = color_q;
    assign bus.load_done    = load_done_q;
    assign bus.load_err     = load_err_q;
    assign bus.tick_lost    = tick_lost_q;
endmodule
